seven_seg_capture: RTL and testbench

Receive-side counterpart of the seven-segment decoder: monitors a multiplexed seven-segment display bus (one-hot digit select plus shared segment lines) and reconstructs the hexadecimal value shown on each digit. Used in self-checking display paths and as a bench monitor to read back what the display driver actually emits. Filters select/segment glitches with a stability counter, decodes each settled pattern back to a 4-bit nibble and flags patterns that are not legal hex glyphs.

---
 rtl/seven_seg_capture.sv | 178 +++++++++++++++++
 tb/tb_seven_seg_capture.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: monitors a multiplexed seven-segment bus (one-hot digit
// select plus shared segments) and reconstructs the hex nibble on each digit.
// A sample must hold for STABLE_CYCLES consecutive edges before it is decoded,
// which filters select/segment glitches during digit switch-over.
module seven_seg_capture #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 3,
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_DIGITS-1:0]     an_i,
    input  logic [6:0]                seg_i,
    input  logic                      clr_i,
    output logic [4*NUM_DIGITS-1:0]   digits_o,
    output logic [NUM_DIGITS-1:0]     valid_o,
    output logic [NUM_DIGITS-1:0]     err_o,
    output logic                      upd_o,
    output logic [IdxW-1:0]           upd_idx_o
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntTarget = CntW'(STABLE_CYCLES);

    typedef enum logic [1:0] {StIdle, StCount, StCaptured} state_e;

    state_e                    state_q, state_d;
    logic [NUM_DIGITS-1:0]     an_h_q, an_h_d;
    logic [6:0]                seg_h_q, seg_h_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [CntW-1:0]           cnt_inc;
    logic [4*NUM_DIGITS-1:0]   digits_q, digits_d;
    logic [NUM_DIGITS-1:0]     valid_q, valid_d;
    logic [NUM_DIGITS-1:0]     err_q, err_d;
    logic                      upd_q, upd_d;
    logic [IdxW-1:0]           upd_idx_q, upd_idx_d;

    logic                      an_onehot;
    logic                      sample_match;
    logic                      capture;
    logic [IdxW-1:0]           cap_idx;
    logic                      glyph_legal;
    logic [3:0]                glyph_nib;

    // Returns {legal, nibble} for a segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    assign an_onehot    = $onehot(an_i);
    assign sample_match = an_onehot && (an_i == an_h_q) && (seg_i == seg_h_q);
    assign cnt_inc      = cnt_q + CntW'(1);
    assign {glyph_legal, glyph_nib} = decode_glyph(seg_i);

    // Binary index of the selected digit; an_i equals the held select whenever
    // a capture fires, so the live input is used directly.
    always_comb begin
        cap_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_i[i]) begin
                cap_idx = IdxW'(i);
            end
        end
    end

    // Stability filter: next held sample, dwell count and FSM state.
    always_comb begin
        state_d = state_q;
        an_h_d  = an_h_q;
        seg_h_d = seg_h_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (!an_onehot) begin
            an_h_d  = an_i;
            seg_h_d = seg_i;
            cnt_d   = '0;
            state_d = StIdle;
        end else if (!sample_match) begin
            an_h_d  = an_i;
            seg_h_d = seg_i;
            cnt_d   = CntW'(1);
            if (STABLE_CYCLES == 1) begin
                capture = 1'b1;
                state_d = StCaptured;
            end else begin
                state_d = StCount;
            end
        end else begin
            case (state_q)
                StCount: begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntTarget) begin
                        capture = 1'b1;
                        state_d = StCaptured;
                    end
                end
                // One capture per dwell; a matching sample in IDLE cannot occur
                // because the held select there is never one-hot.
                default: ;
            endcase
        end
    end

    // Capture datapath: clear first, then the captured digit overrides it.
    always_comb begin
        digits_d  = clr_i ? '0 : digits_q;
        valid_d   = clr_i ? '0 : valid_q;
        err_d     = clr_i ? '0 : err_q;
        upd_d     = capture;
        upd_idx_d = capture ? cap_idx : upd_idx_q;
        if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (an_i[i]) begin
                    if (glyph_legal) begin
                        digits_d[4*i +: 4] = glyph_nib;
                        valid_d[i]         = 1'b1;
                        err_d[i]           = 1'b0;
                    end else begin
                        valid_d[i]         = 1'b0;
                        err_d[i]           = 1'b1;
                    end
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            an_h_q    <= '0;
            seg_h_q   <= '0;
            cnt_q     <= '0;
            digits_q  <= '0;
            valid_q   <= '0;
            err_q     <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            an_h_q    <= an_h_d;
            seg_h_q   <= seg_h_d;
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
        end
    end

    assign digits_o  = digits_q;
    assign valid_o   = valid_q;
    assign err_o     = err_q;
    assign upd_o     = upd_q;
    assign upd_idx_o = upd_idx_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: dwell-level vector table, hand-written glitch,
// clear and reset sequences, then randomized scanning against a run-length model.
module tb_seven_seg_capture;

    localparam int ND = 4;
    localparam int SC = 3;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        clr_i = 1'b0;
    logic [3:0]  an_i = '0;
    logic [6:0]  seg_i = '0;
    logic [15:0] digits_o;
    logic [3:0]  valid_o;
    logic [3:0]  err_o;
    logic        upd_o;
    logic [1:0]  upd_idx_o;

    always #5 clk = ~clk;

    seven_seg_capture #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .an_i      (an_i),
        .seg_i     (seg_i),
        .clr_i     (clr_i),
        .digits_o  (digits_o),
        .valid_o   (valid_o),
        .err_o     (err_o),
        .upd_o     (upd_o),
        .upd_idx_o (upd_idx_o)
    );

    int total = 0;
    int bad = 0;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: length of the current run of identical one-hot samples.
    logic [15:0] m_digits;
    logic [3:0]  m_valid;
    logic [3:0]  m_err;
    logic        m_upd;
    logic [1:0]  m_idx;
    logic [3:0]  p_an;
    logic [6:0]  p_seg;
    int          run;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_digits = '0; m_valid = '0; m_err = '0; m_upd = 1'b0; m_idx = '0;
        p_an = '0; p_seg = '0; run = 0;
    endtask

    task automatic model_edge(input logic [3:0] an, input logic [6:0] seg, input logic clr);
        bit onehot;
        bit legal;
        int nib;
        int k;
        onehot = ($countones(an) == 1);
        if (!onehot) run = 0;
        else if (an == p_an && seg == p_seg) run++;
        else run = 1;
        p_an = an;
        p_seg = seg;
        m_upd = 1'b0;
        if (clr) begin
            m_digits = '0; m_valid = '0; m_err = '0;
        end
        if (onehot && run == SC) begin
            legal = 0; nib = 0; k = 0;
            for (int j = 0; j < 16; j++) if (glyph[j] == seg) begin legal = 1; nib = j; end
            for (int j = 0; j < ND; j++) if (an[j]) k = j;
            if (legal) begin
                m_digits[4*k +: 4] = 4'(nib);
                m_valid[k] = 1'b1;
                m_err[k] = 1'b0;
            end else begin
                m_valid[k] = 1'b0;
                m_err[k] = 1'b1;
            end
            m_upd = 1'b1;
            m_idx = 2'(k);
        end
    endtask

    task automatic step(input logic [3:0] an, input logic [6:0] seg, input logic clr);
        an_i = an; seg_i = seg; clr_i = clr;
        @(posedge clk);
        model_edge(an, seg, clr);
        #1;
        check("model", {digits_o, valid_o, err_o, upd_o, upd_idx_o},
              {m_digits, m_valid, m_err, m_upd, m_idx});
    endtask

    task automatic run_dwell(input logic [3:0] an, input logic [6:0] seg, input int clr_at,
                             input int len, output int pulses, output int first_off);
        pulses = 0;
        first_off = -1;
        for (int c = 0; c < len; c++) begin
            step(an, seg, clr_at == c);
            if (upd_o) begin
                pulses++;
                if (first_off < 0) first_off = c;
            end
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #2;
        check("reset_async", {digits_o, valid_o, err_o, upd_o, upd_idx_o}, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          clr_at;
        int          len;
        logic [15:0] exp_digits;
        logic [3:0]  exp_valid;
        logic [3:0]  exp_err;
        int          exp_pulses;
        int          exp_off;
        logic [1:0]  exp_idx;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] an, input logic [6:0] seg, input int clr_at,
                                input int len, input logic [15:0] d, input logic [3:0] v,
                                input logic [3:0] e, input int p, input int off,
                                input logic [1:0] idx);
        vec_t r;
        r.an = an; r.seg = seg; r.clr_at = clr_at; r.len = len;
        r.exp_digits = d; r.exp_valid = v; r.exp_err = e;
        r.exp_pulses = p; r.exp_off = off; r.exp_idx = idx;
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int p;
        int off;
        logic [3:0] r_an;
        logic [6:0] r_seg;
        int r_len;

        // Scan, illegal selects, glyph sweep, illegal glyph, clear, clear+capture,
        // back-to-back minimum dwells.
        vecs.push_back(mk(4'b0001, 7'h06, -1, 5, 16'h0001, 4'h1, 4'h0, 1, 2, 2'd0));
        vecs.push_back(mk(4'b0010, 7'h5B, -1, 5, 16'h0021, 4'h3, 4'h0, 1, 2, 2'd1));
        vecs.push_back(mk(4'b0100, 7'h4F, -1, 5, 16'h0321, 4'h7, 4'h0, 1, 2, 2'd2));
        vecs.push_back(mk(4'b1000, 7'h66, -1, 5, 16'h4321, 4'hF, 4'h0, 1, 2, 2'd3));
        vecs.push_back(mk(4'b0000, 7'h3F, -1, 10, 16'h4321, 4'hF, 4'h0, 0, -1, 2'd3));
        vecs.push_back(mk(4'b0011, 7'h3F, -1, 10, 16'h4321, 4'hF, 4'h0, 0, -1, 2'd3));
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(4'b0001, glyph[i], -1, 4, 16'h4320 | 16'(i), 4'hF, 4'h0,
                              1, 2, 2'd0));
        vecs.push_back(mk(4'b0001, 7'h00, -1, 4, 16'h432F, 4'hE, 4'h1, 1, 2, 2'd0));
        vecs.push_back(mk(4'b0000, 7'h00, 0, 3, 16'h0000, 4'h0, 4'h0, 0, -1, 2'd0));
        vecs.push_back(mk(4'b0100, 7'h7D, 2, 4, 16'h0600, 4'h4, 4'h0, 1, 2, 2'd2));
        vecs.push_back(mk(4'b0001, 7'h07, -1, 3, 16'h0607, 4'h5, 4'h0, 1, 2, 2'd0));
        vecs.push_back(mk(4'b0010, 7'h7F, -1, 3, 16'h0687, 4'h7, 4'h0, 1, 2, 2'd1));

        #1;
        do_reset();

        foreach (vecs[i]) begin
            run_dwell(vecs[i].an, vecs[i].seg, vecs[i].clr_at, vecs[i].len, p, off);
            check($sformatf("v%0d_pulses", i), 64'(p), 64'(vecs[i].exp_pulses));
            check($sformatf("v%0d_offset", i), 64'(off), 64'(vecs[i].exp_off));
            check($sformatf("v%0d_digits", i), 64'(digits_o), 64'(vecs[i].exp_digits));
            check($sformatf("v%0d_valid", i), 64'(valid_o), 64'(vecs[i].exp_valid));
            check($sformatf("v%0d_err", i), 64'(err_o), 64'(vecs[i].exp_err));
            check($sformatf("v%0d_idx", i), 64'(upd_idx_o), 64'(vecs[i].exp_idx));
        end

        // Glitch during COUNT restarts the dwell.
        run_dwell(4'b0010, 7'h6D, -1, 4, p, off);
        check("pre_glitch_digits", 64'(digits_o), 64'h0657);
        run_dwell(4'b0010, 7'h7F, -1, 2, p, off);
        check("glitch_partial_pulses", 64'(p), 64'd0);
        run_dwell(4'b0010, 7'h7E, -1, 1, p, off);
        check("glitch_cycle_pulses", 64'(p), 64'd0);
        run_dwell(4'b0010, 7'h7F, -1, 4, p, off);
        check("glitch_restart_pulses", 64'(p), 64'd1);
        check("glitch_restart_offset", 64'(off), 64'd2);
        check("glitch_digit1", 64'(digits_o[7:4]), 64'h8);

        // Glitch after CAPTURED then return: second capture of the same digit.
        run_dwell(4'b0010, 7'h7E, -1, 1, p, off);
        check("post_cap_glitch_pulses", 64'(p), 64'd0);
        run_dwell(4'b0010, 7'h7F, -1, 4, p, off);
        check("recapture_pulses", 64'(p), 64'd1);
        check("recapture_offset", 64'(off), 64'd2);
        check("recapture_idx", 64'(upd_idx_o), 64'd1);

        // Reset mid-dwell discards the partial count.
        run_dwell(4'b1000, 7'h39, -1, 2, p, off);
        check("pre_reset_pulses", 64'(p), 64'd0);
        do_reset();
        run_dwell(4'b1000, 7'h39, -1, 4, p, off);
        check("post_reset_offset", 64'(off), 64'd2);
        check("post_reset_digits", {digits_o, valid_o, err_o}, {16'hC000, 4'h8, 4'h0});

        // Randomized scanning checked every cycle against the model.
        for (int d = 0; d < 300; d++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 7) r_an = 4'(1 << $urandom_range(0, 3));
            else if (r == 7) r_an = 4'b0000;
            else r_an = 4'($urandom);
            if ($urandom_range(0, 4) == 0) r_seg = 7'($urandom);
            else r_seg = glyph[$urandom_range(0, 15)];
            r_len = $urandom_range(1, 6);
            for (int c = 0; c < r_len; c++) step(r_an, r_seg, $urandom_range(0, 19) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
